uart_cmd_ctrl: RTL and testbench

UART_CMD_CTRL -- requirements
Module: uart_cmd_ctrl

---
 rtl/uart_cmd_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_uart_cmd_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// uart_cmd_ctrl
//
// Turns a byte stream from a UART receiver into single register-file writes.
// Frame format:
//   UART_CMD_CHECKSUM_EN defined   : HDR, addr, data, csum
//                                    where csum = (HDR + addr + data) mod 256
//   UART_CMD_CHECKSUM_EN undefined : HDR, addr, data
// Bytes that arrive in IDLE and are not HDR are dropped without an error.
// A frame is abandoned, and an error is flagged, if the gap between two bytes
// inside it runs out, or if its checksum does not match. A byte that arrives
// while a write is still pending is dropped and flagged as an error.
//
// Parameters
//   HDR      frame header byte
//   TIMEOUT  longest allowed inter-byte gap, in clk cycles (must be >= 2)
//
// Ports
//   clk       in   system clock, rising-edge active
//   rstn      in   asynchronous active-low reset
//   rcv       in   one-cycle byte strobe from the UART receiver
//   data      in   received byte, valid while rcv = 1
//   wr_ready  in   register file accepts the pending write
//   wr_en     out  write request, held until wr_ready
//   wr_addr   out  write address
//   wr_data   out  write data
//   busy      out  high whenever a frame is in progress or a write is pending
//   err       out  one-cycle pulse per frame error
//   err_cnt   out  saturating count of frame errors
//
// Build option: UART_CMD_CHECKSUM_EN adds the checksum byte and CSUM state.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | hunting for HDR; everything else is discarded
// ADDR  | header seen, waiting for the address byte
// DATA  | address captured, waiting for the data byte
// CSUM  | data captured, waiting for the checksum byte (option only)
// WRITE | wr_en asserted, waiting for wr_ready
// -----------------------------------------------------------------------------
module uart_cmd_ctrl #(
  parameter logic [7:0] HDR     = 8'hA5,
  parameter int         TIMEOUT = 24000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rcv,
  input  logic [7:0] data,
  input  logic       wr_ready,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy,
  output logic       err,
  output logic [7:0] err_cnt
);

  localparam int GW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [GW-1:0] GAP_MAX = GW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_DATA  = 3'd2,
`ifdef UART_CMD_CHECKSUM_EN
    S_CSUM  = 3'd3,
`endif
    S_WRITE = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [7:0]    addr_q, addr_d;
  logic [7:0]    data_q, data_d;
  logic          wr_en_q, wr_en_d;
  logic          err_q, err_d;
  logic [7:0]    err_cnt_q, err_cnt_d;

  logic          in_frame;
  logic          timeout_hit;
`ifdef UART_CMD_CHECKSUM_EN
  logic [7:0]    csum_exp;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      gap_q     <= '0;
      addr_q    <= 8'h00;
      data_q    <= 8'h00;
      wr_en_q   <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      gap_q     <= gap_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      wr_en_q   <= wr_en_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    data_d      = data_q;
    err_d       = 1'b0;
    in_frame    = (state_q != S_IDLE) && (state_q != S_WRITE);
    // A byte landing on the expiry cycle takes precedence over the timeout.
    timeout_hit = in_frame && !rcv && (gap_q == GAP_MAX);
`ifdef UART_CMD_CHECKSUM_EN
    csum_exp    = HDR + addr_q + data_q;
`endif

    if (!in_frame || rcv || timeout_hit) begin
      gap_d = '0;
    end else begin
      gap_d = gap_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (rcv && (data == HDR)) begin
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        if (rcv) begin
          addr_d  = data;
          state_d = S_DATA;
        end else if (timeout_hit) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end
      end
      S_DATA: begin
        if (rcv) begin
          data_d  = data;
`ifdef UART_CMD_CHECKSUM_EN
          state_d = S_CSUM;
`else
          state_d = S_WRITE;
`endif
        end else if (timeout_hit) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end
      end
`ifdef UART_CMD_CHECKSUM_EN
      S_CSUM: begin
        if (rcv) begin
          if (data == csum_exp) begin
            state_d = S_WRITE;
          end else begin
            state_d = S_IDLE;
            err_d   = 1'b1;
          end
        end else if (timeout_hit) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end
      end
`endif
      S_WRITE: begin
        // An overrun byte is counted but never disturbs the pending write.
        if (rcv) begin
          err_d = 1'b1;
        end
        if (wr_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    wr_en_d = (state_d == S_WRITE);

    if (err_d && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = addr_q;
  assign wr_data = data_q;
  assign busy    = (state_q != S_IDLE);
  assign err     = err_q;
  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
module tb_uart_cmd_ctrl;

  localparam logic [7:0] HDR = 8'hA5;
  localparam int         TMO = 40;
`ifdef UART_CMD_CHECKSUM_EN
  localparam int         FLEN = 4;
  localparam int         E0   = 1;
`else
  localparam int         FLEN = 3;
  localparam int         E0   = 0;
`endif

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       rcv = 1'b0;
  logic [7:0] data = 8'h00;
  logic       wr_ready = 1'b0;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;
  logic       err;
  logic [7:0] err_cnt;

  uart_cmd_ctrl #(.HDR(HDR), .TIMEOUT(TMO)) dut (
    .clk(clk), .rstn(rstn), .rcv(rcv), .data(data), .wr_ready(wr_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
    .err(err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: counts bytes of the current frame and cycles since the
  // last byte; no notion of the DUT's state encoding.
  int         m_n = 0;
  int         m_since = 0;
  bit         m_wr = 0;
  bit         m_err = 0;
  logic [7:0] m_addr = 8'h00;
  logic [7:0] m_data = 8'h00;
  logic [7:0] m_cnt = 8'h00;
  logic [7:0] m_bytes [4];

  always @(posedge clk) begin
    bit e;
    e = 0;
    if (!rstn) begin
      m_n = 0; m_since = 0; m_wr = 0; m_addr = 8'h00; m_data = 8'h00; m_cnt = 8'h00;
    end else begin
      if (m_wr) begin
        if (rcv) e = 1;
        if (wr_ready) m_wr = 0;
      end else if (m_n == 0) begin
        if (rcv && data == HDR) begin
          m_n = 1;
          m_since = 0;
        end
      end else if (rcv) begin
        m_bytes[m_n] = data;
        if (m_n == 1) m_addr = data;
        if (m_n == 2) m_data = data;
        m_n++;
        m_since = 0;
        if (m_n == FLEN) begin
          m_n = 0;
          if (FLEN == 3 || m_bytes[3] == 8'(HDR + m_bytes[1] + m_bytes[2])) m_wr = 1;
          else e = 1;
        end
      end else begin
        m_since++;
        if (m_since == TMO) begin
          m_n = 0;
          e = 1;
        end
      end
      if (e && m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
    end
    m_err = e;
    #1;
    chk("wr_en",   wr_en,   m_wr);
    chk("wr_addr", wr_addr, m_addr);
    chk("wr_data", wr_data, m_data);
    chk("busy",    busy,    m_wr || (m_n != 0));
    chk("err",     err,     m_err);
    chk("err_cnt", err_cnt, m_cnt);
  end

  int rdy_mode = 0;

  task automatic cyc(input bit r, input logic [7:0] d);
    @(negedge clk);
    rcv  = r;
    data = d;
    case (rdy_mode)
      0:       wr_ready = 1'b0;
      1:       wr_ready = 1'b1;
      default: wr_ready = ($urandom_range(0, 3) == 0);
    endcase
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 8'($urandom));
  endtask

  function automatic int pick_gap();
    if ($urandom_range(0, 9) < 7) return $urandom_range(0, 3);
    return TMO - 2 + $urandom_range(0, 2);
  endfunction

  task automatic send_frame(input logic [7:0] a, input logic [7:0] d, input bit good, input bit rgap);
    cyc(1'b1, HDR);
    if (rgap) idle(pick_gap());
    cyc(1'b1, a);
    if (rgap) idle(pick_gap());
    cyc(1'b1, d);
`ifdef UART_CMD_CHECKSUM_EN
    if (rgap) idle(pick_gap());
    cyc(1'b1, good ? 8'(HDR + a + d) : 8'(HDR + a + d + 8'd1));
`endif
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rstn = 1'b0;
    rcv  = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    // Reset state
    idle(3);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err_cnt", err_cnt, 0);
    @(negedge clk);
    rstn = 1'b1;

    // Good frame, write held while wr_ready low
    rdy_mode = 0;
    send_frame(8'h10, 8'h3C, 1'b1, 1'b0);
    cyc(1'b0, 8'h00);
    chk("good_wr_en", wr_en, 1);
    chk("good_addr", wr_addr, 8'h10);
    chk("good_data", wr_data, 8'h3C);
    chk("good_err_cnt", err_cnt, 0);
    rdy_mode = 1;
    cyc(1'b0, 8'h00);
    cyc(1'b0, 8'h00);
    chk("good_done", wr_en, 0);
    chk("good_idle", busy, 0);

`ifdef UART_CMD_CHECKSUM_EN
    // Bad checksum
    send_frame(8'h10, 8'h3C, 1'b0, 1'b0);
    cyc(1'b0, 8'h00);
    chk("bad_err", err, 1);
    chk("bad_err_cnt", err_cnt, 1);
    chk("bad_busy", busy, 0);
    chk("bad_wr_en", wr_en, 0);
    cyc(1'b0, 8'h00);
    chk("bad_err_pulse", err, 0);
`endif

    // Timeout after A5,22
    cyc(1'b1, HDR);
    cyc(1'b1, 8'h22);
    idle(TMO);
    chk("tmo_before", busy, 1);
    chk("tmo_before_err", err, 0);
    cyc(1'b0, 8'h00);
    chk("tmo_err", err, 1);
    chk("tmo_busy", busy, 0);
    chk("tmo_err_cnt", err_cnt, E0 + 1);
    send_frame(8'h22, 8'h55, 1'b1, 1'b0);
    cyc(1'b0, 8'h00);
    chk("tmo_next_wr", wr_en, 1);
    chk("tmo_next_addr", wr_addr, 8'h22);
    chk("tmo_next_data", wr_data, 8'h55);
    cyc(1'b0, 8'h00);

    // Long stall with overrun byte
    rdy_mode = 0;
    send_frame(8'h40, 8'h41, 1'b1, 1'b0);
    idle(20);
    cyc(1'b1, 8'h77);
    idle(30);
    chk("stall_wr_en", wr_en, 1);
    chk("stall_data", wr_data, 8'h41);
    chk("stall_err_cnt", err_cnt, E0 + 2);
    rdy_mode = 1;
    cyc(1'b0, 8'h00);
    cyc(1'b0, 8'h00);
    chk("stall_done", wr_en, 0);

    // Reset mid-frame
    cyc(1'b1, HDR);
    cyc(1'b1, 8'h10);
    pulse_reset();
    chk("mrst_busy", busy, 0);
    chk("mrst_addr", wr_addr, 0);
    chk("mrst_err_cnt", err_cnt, 0);
    cyc(1'b1, 8'h3C);
    cyc(1'b1, 8'hF1);
    cyc(1'b0, 8'h00);
    chk("mrst_no_wr", wr_en, 0);
    chk("mrst_no_busy", busy, 0);

    // Randomized traffic
    for (int it = 0; it < 250; it++) begin
      int ch;
      logic [7:0] b;
      rdy_mode = $urandom_range(0, 2);
      ch = $urandom_range(0, 19);
      b  = 8'($urandom);
      if (ch == 0) begin
        pulse_reset();
      end else if (ch < 3) begin
        cyc(1'b1, (b == HDR) ? 8'h5A : b);
      end else if (ch < 5) begin
        cyc(1'b1, b);
      end else if (ch < 7) begin
        cyc(1'b1, HDR);
        idle(pick_gap());
        cyc(1'b1, b);
      end else begin
        send_frame(8'($urandom), 8'($urandom), ($urandom_range(0, 3) != 0), 1'b1);
      end
      idle($urandom_range(0, 3));
    end

    // Error counter saturation
    rdy_mode = 1;
    idle(2);
    pulse_reset();
    rdy_mode = 0;
    send_frame(8'h01, 8'h02, 1'b1, 1'b0);
    repeat (300) cyc(1'b1, 8'($urandom));
    cyc(1'b0, 8'h00);
    chk("sat_err_cnt", err_cnt, 8'hFF);
    chk("sat_wr_en", wr_en, 1);
    rdy_mode = 1;
    cyc(1'b0, 8'h00);
    cyc(1'b0, 8'h00);
    chk("sat_done", wr_en, 0);
    chk("sat_hold", err_cnt, 8'hFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
